// File: rtl/iscbdiv_ctrl.sv
// Job controller for a unary (stochastic) divider: turns binary operands into correlated
// bitstreams, counts quotient ones over one full stream period and returns a binary result.
module iscbdiv_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned WARMUP        = 4,
    parameter int unsigned DEPLOG_KERNEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_dividend,
    input  logic [WIDTH-1:0]         in_divisor,
    output logic                     div_dividend,
    output logic                     div_divisor,
    output logic [DEPLOG_KERNEL-1:0] div_randNum,
    input  logic                     div_quotient,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_quotient,
    output logic                     out_div0,
    output logic                     busy
);

    localparam int unsigned SEQ_W  = WIDTH + 4;
    localparam int unsigned ONES_W = WIDTH + 1;

    localparam logic [SEQ_W-1:0]  SEQ_ONE   = SEQ_W'(1);
    localparam logic [SEQ_W-1:0]  WARM_LAST = SEQ_W'(WARMUP - 1);
    localparam logic [SEQ_W-1:0]  RUN_LAST  = SEQ_W'((1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0]  Q_MAX     = '1;
    localparam logic [7:0]        LFSR_SEED = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StRun,
        StDone
    } state_e;

    state_e             r_state, w_state_nxt;
    logic [SEQ_W-1:0]   r_seq, w_seq_nxt;
    logic [ONES_W-1:0]  r_ones, w_ones_nxt;
    logic [WIDTH-1:0]   r_op_dd, w_op_dd_nxt;
    logic [WIDTH-1:0]   r_op_dv, w_op_dv_nxt;
    logic [WIDTH-1:0]   r_quot, w_quot_nxt;
    logic               r_div0, w_div0_nxt;
    logic [7:0]         r_lfsr, w_lfsr_nxt;

    logic               w_stream_en;
    logic [WIDTH-1:0]   w_run_idx;
    logic [WIDTH-1:0]   w_sel;
    logic [ONES_W-1:0]  w_ones_fin;
    logic [WIDTH-1:0]   w_ones_sat;
    logic               w_lfsr_fb;

    assign w_stream_en = (r_state == StWarmup) || (r_state == StRun);

    // Run index stays at 0 through warm-up so the divider sees a steady stream to settle on.
    assign w_run_idx = (r_state == StRun) ? r_seq[WIDTH-1:0] : '0;

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_sel[i] = w_run_idx[WIDTH-1-i];
        end
    end

    // One shared comparator value gives maximally correlated dividend/divisor streams.
    assign div_dividend = w_stream_en && (w_sel < r_op_dd);
    assign div_divisor  = w_stream_en && (w_sel < r_op_dv);

    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign div_randNum = r_lfsr[DEPLOG_KERNEL-1:0];

    // Include the final RUN sample; a full stream of ones saturates to the top code.
    assign w_ones_fin = r_ones + ONES_W'(div_quotient);
    assign w_ones_sat = w_ones_fin[WIDTH] ? Q_MAX : w_ones_fin[WIDTH-1:0];

    assign in_ready     = (r_state == StIdle);
    assign out_valid    = (r_state == StDone);
    assign busy         = (r_state != StIdle);
    assign out_quotient = r_quot;
    assign out_div0     = r_div0;

    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = r_seq;
        w_ones_nxt  = r_ones;
        w_op_dd_nxt = r_op_dd;
        w_op_dv_nxt = r_op_dv;
        w_quot_nxt  = r_quot;
        w_div0_nxt  = r_div0;
        w_lfsr_nxt  = r_lfsr;

        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_op_dd_nxt = in_dividend;
                    w_op_dv_nxt = in_divisor;
                    w_seq_nxt   = '0;
                    w_ones_nxt  = '0;
                    if (in_divisor == '0) begin
                        w_state_nxt = StDone;
                        w_quot_nxt  = Q_MAX;
                        w_div0_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = StWarmup;
                    end
                end
            end
            StWarmup: begin
                w_lfsr_nxt = {r_lfsr[6:0], w_lfsr_fb};
                if (r_seq == WARM_LAST) begin
                    w_seq_nxt   = '0;
                    w_state_nxt = StRun;
                end else begin
                    w_seq_nxt = r_seq + SEQ_ONE;
                end
            end
            StRun: begin
                w_lfsr_nxt = {r_lfsr[6:0], w_lfsr_fb};
                w_ones_nxt = w_ones_fin;
                if (r_seq == RUN_LAST) begin
                    w_state_nxt = StDone;
                    w_quot_nxt  = w_ones_sat;
                    w_div0_nxt  = 1'b0;
                end else begin
                    w_seq_nxt = r_seq + SEQ_ONE;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_seq   <= '0;
            r_ones  <= '0;
            r_op_dd <= '0;
            r_op_dv <= '0;
            r_quot  <= '0;
            r_div0  <= 1'b0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_state <= w_state_nxt;
            r_seq   <= w_seq_nxt;
            r_ones  <= w_ones_nxt;
            r_op_dd <= w_op_dd_nxt;
            r_op_dv <= w_op_dv_nxt;
            r_quot  <= w_quot_nxt;
            r_div0  <= w_div0_nxt;
            r_lfsr  <= w_lfsr_nxt;
        end
    end

endmodule

// File: tb/tb_iscbdiv_ctrl.sv
// Randomized self-checking bench for iscbdiv_ctrl with stub and behavioural divider kernels.
module tb_iscbdiv_ctrl;

    localparam int W    = 8;
    localparam int WU   = 4;
    localparam int DEP  = 1;
    localparam int NRUN = 1 << W;
    localparam int QMAX = NRUN - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_dividend;
    logic [W-1:0]   in_divisor;
    logic           div_dividend;
    logic           div_divisor;
    logic [DEP-1:0] div_randNum;
    logic           div_quotient;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_quotient;
    logic           out_div0;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    // Quotient source: 0 = copy dividend, 1 = constant one, 2 = random bits, 3 = divider model
    int             mode = 0;
    logic           q_rand = 1'b0;
    logic [(1<<DEP)-1:0] hist;
    logic           real_q;
    logic [7:0]     lfsr_m;

    iscbdiv_ctrl #(
        .WIDTH         (W),
        .WARMUP        (WU),
        .DEPLOG_KERNEL (DEP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_randNum  (div_randNum),
        .div_quotient (div_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_div0     (out_div0),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Correlated unary divider: pass the dividend where the divisor is 1, else replay history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (div_divisor) begin
            hist <= (hist << 1) | {{((1<<DEP)-1){1'b0}}, div_dividend};
        end
    end

    always_comb begin
        real_q = div_divisor ? div_dividend : hist[div_randNum];
        case (mode)
            0:       div_quotient = div_dividend;
            1:       div_quotient = 1'b1;
            2:       div_quotient = q_rand;
            default: div_quotient = real_q;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
        logic [W-1:0] o;
        for (int i = 0; i < W; i++) o[i] = v[W-1-i];
        return o;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // One job: accept, per-cycle stream checks, result checks, backpressure, handshake.
    // abort_at >= 0 pulses reset at that cycle after accept instead of finishing the job.
    task automatic run_job(input logic [W-1:0] dd, input logic [W-1:0] dv, input int md,
                           input int hold, input int abort_at);
        int lat, k, r, mism, dd_ones, dv_ones, qsum, hold_bad, idle_bad, expq;
        logic [W-1:0] s;
        logic [W-1:0] q0;
        logic         d0;
        bit           inrun;
        mode = md;
        mism = 0; dd_ones = 0; dv_ones = 0; qsum = 0; hold_bad = 0; idle_bad = 0;
        out_ready = 1'b0;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_dividend = dd; in_divisor = dv;
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < WU + NRUN + 20) begin
            k = lat - 1;
            inrun = (k >= WU);
            r = inrun ? k - WU : 0;
            s = bitrev(W'(r));
            if (abort_at >= 0 && k == abort_at) begin
                rst_n = 1'b0; #1;
                check("abort_out_valid", 32'(out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_in_ready", 32'(in_ready), 32'd1);
                check("abort_div_divisor", 32'(div_divisor), 32'd0);
                in_valid = 1'b0;
                lfsr_m = 8'h01;
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b1;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (out_valid || busy) idle_bad++;
                end
                check("abort_no_output", 32'(idle_bad), 32'd0);
                return;
            end
            if (div_dividend !== (s < dd)) mism++;
            if (div_divisor !== (s < dv)) mism++;
            if (div_randNum !== lfsr_m[DEP-1:0]) mism++;
            if (busy !== 1'b1 || in_ready !== 1'b0) mism++;
            lfsr_m = lfsr_step(lfsr_m);
            q_rand = 1'($urandom_range(0, 1));
            if (inrun) begin
                dd_ones += int'(div_dividend);
                dv_ones += int'(div_divisor);
                if (md == 2) qsum += int'(q_rand);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_dividend = W'($urandom);
            in_divisor = W'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), (dv != 0) ? 32'(WU + NRUN + 1) : 32'd1);
        if (dv != 0) begin
            check("stream_pattern", 32'(mism), 32'd0);
            check("dividend_ones", 32'(dd_ones), 32'(dd));
            check("divisor_ones", 32'(dv_ones), 32'(dv));
        end
        if (dv == 0)      expq = QMAX;
        else if (md == 0) expq = int'(dd);
        else if (md == 1) expq = QMAX;
        else              expq = (qsum > QMAX) ? QMAX : qsum;
        if (md == 3 && dv != 0) begin
            expq = (int'(dd) * NRUN) / int'(dv);
            check("real_quot_band",
                  32'((int'(out_quotient) >= expq - 16) && (int'(out_quotient) <= expq + 16)),
                  32'd1);
        end else begin
            check("quotient", 32'(out_quotient), 32'(expq));
        end
        check("div0", 32'(out_div0), 32'(dv == 0));
        check("done_streams_low", 32'({div_dividend, div_divisor}), 32'd0);
        q0 = out_quotient;
        d0 = out_div0;
        repeat (hold) begin
            in_valid = 1'b1;
            in_dividend = W'($urandom);
            in_divisor = W'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_quotient !== q0 || out_div0 !== d0 ||
                in_ready !== 1'b0 || busy !== 1'b1) hold_bad++;
        end
        if (hold > 0) check("backpressure_hold", 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        check("handshake_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("post_handshake", 32'({out_valid, busy, in_ready}), 32'b001);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_dividend = '0;
        in_divisor = '0;
        out_ready = 1'b0;
        lfsr_m = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_quotient", 32'(out_quotient), 32'd0);
        check("rst_div0", 32'(out_div0), 32'd0);
        check("rst_streams", 32'({div_dividend, div_divisor}), 32'd0);
        check("rst_randnum", 32'(div_randNum), 32'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);

        run_job(8'd100, 8'd200, 0, 10, -1);
        run_job(8'd37,  8'd5,   1, 0,  -1);
        run_job(8'd50,  8'd0,   0, 3,  -1);
        run_job(8'd255, 8'd255, 0, 1,  -1);
        run_job(8'd0,   8'd1,   0, 0,  -1);
        run_job(8'd100, 8'd200, 0, 0,  WU + 100);
        run_job(8'd64,  8'd128, 3, 2,  -1);

        for (int j = 0; j < 12; j++) begin
            logic [W-1:0] dd, dv;
            dd = W'($urandom);
            dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_job(dd, dv, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
